// File: rtl/wired_pkg_dispatch_pkg.sv
// wired_pkg_dispatch_pkg: shared payload, fetch-exception and dispatch-state types for the packet dispatcher
package wired_pkg_dispatch_pkg;

    typedef struct packed {
        logic adef;
        logic tlbr;
        logic pif;
        logic ppi;
    } fetch_excp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        fetch_excp_t fetch_excp;
    } pipeline_ctrl_pack_t;

    typedef enum logic [1:0] {EMPTY, SLOT0, SLOT1} dispatch_state_e;

    function automatic dispatch_state_e load_state(input logic [1:0] mask);
        return mask[0] ? SLOT0 : mask[1] ? SLOT1 : EMPTY;
    endfunction

endpackage

// File: rtl/wired_pkg_dispatch.sv
// wired_pkg_dispatch: splits two-slot packets (pkg_valid_i/pkg_ready_o/pkg_mask_i/pkg_i) into single instructions (inst_valid_o/inst_ready_i/inst_o/inst_seq_o/inst_last_o), flush_i discards held state
module wired_pkg_dispatch
    import wired_pkg_dispatch_pkg::*;
#(
    parameter int SEQ_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      pkg_valid_i,
    output logic                      pkg_ready_o,
    input  logic [1:0]                pkg_mask_i,
    input  pipeline_ctrl_pack_t [1:0] pkg_i,
    output logic                      inst_valid_o,
    input  logic                      inst_ready_i,
    output pipeline_ctrl_pack_t       inst_o,
    output logic [SEQ_WIDTH-1:0]      inst_seq_o,
    output logic                      inst_last_o
);

    dispatch_state_e           state_q, state_d;
    pipeline_ctrl_pack_t [1:0] pkg_q;
    logic [1:0]                mask_q;
    logic                      ptr_q;
    logic [SEQ_WIDTH-1:0]      seq_q;
    logic                      hs;
    logic                      accept;

    always_comb begin
        inst_valid_o = state_q != EMPTY;
        hs           = inst_valid_o & inst_ready_i;
        inst_last_o  = state_q == SLOT1 || (state_q == SLOT0 && !(mask_q[1] && pkg_q[0].fetch_excp == '0));
        pkg_ready_o  = state_q == EMPTY || (hs && inst_last_o);
        accept       = pkg_valid_i & pkg_ready_o;
        state_d      = flush_i ? EMPTY : accept ? load_state(pkg_mask_i) : !hs ? state_q : inst_last_o ? EMPTY : SLOT1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= 1'b0;
            mask_q  <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= state_d == SLOT1;
            if (accept && !flush_i) mask_q <= pkg_mask_i;
            if (hs) seq_q <= seq_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !flush_i) pkg_q <= pkg_i;
    end

    assign inst_o     = pkg_q[ptr_q];
    assign inst_seq_o = seq_q;

endmodule

// File: tb/tb_wired_pkg_dispatch.sv
// tb_wired_pkg_dispatch: table, corner-case and randomized checks of the packet dispatcher against a queue model
module tb_wired_pkg_dispatch;
    import wired_pkg_dispatch_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      flush_i = 1'b0;
    logic                      pkg_valid_i = 1'b0;
    logic                      pkg_ready_o;
    logic [1:0]                pkg_mask_i = '0;
    pipeline_ctrl_pack_t [1:0] pkg_i = '0;
    logic                      inst_valid_o;
    logic                      inst_ready_i = 1'b0;
    pipeline_ctrl_pack_t       inst_o;
    logic [7:0]                inst_seq_o;
    logic                      inst_last_o;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        pipeline_ctrl_pack_t ins;
        bit                  last;
    } ent_t;

    ent_t       q[$];
    logic [7:0] mseq = '0;

    typedef struct {
        bit         pv;
        logic [1:0] m;
        bit         ex;
        bit         rdy;
        bit         fl;
        bit         ev;
        bit         er;
        bit         el;
        logic [7:0] es;
        logic [31:0] epc;
        bit         eex;
    } row_t;

    row_t tbl[13];

    always #5 clk = ~clk;

    wired_pkg_dispatch #(.SEQ_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .flush_i(flush_i),
        .pkg_valid_i(pkg_valid_i),
        .pkg_ready_o(pkg_ready_o),
        .pkg_mask_i(pkg_mask_i),
        .pkg_i(pkg_i),
        .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i),
        .inst_o(inst_o),
        .inst_seq_o(inst_seq_o),
        .inst_last_o(inst_last_o)
    );

    function automatic pipeline_ctrl_pack_t mk(input logic [31:0] pc, input logic [3:0] ex);
        pipeline_ctrl_pack_t p;
        p.pc = pc;
        p.inst = ~pc;
        p.fetch_excp = fetch_excp_t'(ex);
        return p;
    endfunction

    task automatic chk(input string n, input logic [79:0] a, input logic [79:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic push_pkt(input logic [1:0] m, input pipeline_ctrl_pack_t p0, input pipeline_ctrl_pack_t p1);
        bit keep1 = m[1] && (!m[0] || p0.fetch_excp == '0);
        if (m[0]) q.push_back('{p0, !keep1});
        if (keep1) q.push_back('{p1, 1'b1});
    endtask

    task automatic model_check();
        bit mv = q.size() != 0;
        bit lst = mv ? q[0].last : 1'b0;
        chk("valid", 80'(inst_valid_o), 80'(mv));
        chk("ready", 80'(pkg_ready_o), 80'(mv ? (inst_ready_i && lst) : 1'b1));
        chk("last", 80'(inst_last_o), 80'(lst));
        chk("seq", 80'(inst_seq_o), 80'(mseq));
        if (mv) chk("inst", 80'(inst_o), 80'(q[0].ins));
    endtask

    task automatic model_update();
        bit mv = q.size() != 0;
        bit hs = mv && inst_ready_i;
        bit acc = pkg_valid_i && (!mv || (hs && q[0].last));
        if (hs) mseq++;
        if (flush_i) q.delete();
        else begin
            if (hs) q.delete(0);
            if (acc) push_pkt(pkg_mask_i, pkg_i[0], pkg_i[1]);
        end
    endtask

    task automatic drive(input bit pv, input logic [1:0] m, input pipeline_ctrl_pack_t p0,
                         input pipeline_ctrl_pack_t p1, input bit rdy, input bit fl);
        pkg_valid_i = pv;
        pkg_mask_i = m;
        pkg_i[0] = p0;
        pkg_i[1] = p1;
        inst_ready_i = rdy;
        flush_i = fl;
        #4;
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        pkg_valid_i = 1'b0;
        flush_i = 1'b0;
        inst_ready_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", 80'(inst_valid_o), 80'(0));
        chk("rst_seq", 80'(inst_seq_o), 80'(0));
        chk("rst_ready", 80'(pkg_ready_o), 80'(1));
        chk("rst_last", 80'(inst_last_o), 80'(0));
        rst = 1'b0;
        q.delete();
        mseq = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl = '{
            '{1, 2'b10, 0, 1, 0, 0, 1, 0, 8'd0, 32'h0,     0},
            '{1, 2'b00, 0, 1, 0, 1, 1, 1, 8'd0, 32'h1C004, 0},
            '{0, 2'b00, 0, 1, 0, 0, 1, 0, 8'd1, 32'h0,     0},
            '{1, 2'b11, 0, 1, 0, 0, 1, 0, 8'd1, 32'h0,     0},
            '{0, 2'b00, 0, 1, 0, 1, 0, 0, 8'd1, 32'h1C018, 0},
            '{1, 2'b11, 1, 1, 0, 1, 1, 1, 8'd2, 32'h1C01C, 0},
            '{0, 2'b00, 0, 1, 0, 1, 1, 1, 8'd3, 32'h1C028, 1},
            '{0, 2'b00, 0, 1, 0, 0, 1, 0, 8'd4, 32'h0,     0},
            '{1, 2'b11, 0, 0, 0, 0, 1, 0, 8'd4, 32'h0,     0},
            '{1, 2'b01, 0, 0, 0, 1, 0, 0, 8'd4, 32'h1C040, 0},
            '{0, 2'b00, 0, 1, 0, 1, 0, 0, 8'd4, 32'h1C040, 0},
            '{1, 2'b11, 0, 1, 1, 1, 1, 1, 8'd5, 32'h1C044, 0},
            '{0, 2'b00, 0, 1, 0, 0, 1, 0, 8'd6, 32'h0,     0}
        };
        #2;
        chk("rst_valid", 80'(inst_valid_o), 80'(0));
        chk("rst_ready", 80'(pkg_ready_o), 80'(1));
        chk("rst_last", 80'(inst_last_o), 80'(0));
        chk("rst_seq", 80'(inst_seq_o), 80'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].pv, tbl[i].m, mk(32'h1C000 + 32'(i) * 8, tbl[i].ex ? 4'd1 : 4'd0),
                  mk(32'h1C004 + 32'(i) * 8, 4'd0), tbl[i].rdy, tbl[i].fl);
            chk($sformatf("t%0d_valid", i), 80'(inst_valid_o), 80'(tbl[i].ev));
            chk($sformatf("t%0d_ready", i), 80'(pkg_ready_o), 80'(tbl[i].er));
            chk($sformatf("t%0d_last", i), 80'(inst_last_o), 80'(tbl[i].el));
            chk($sformatf("t%0d_seq", i), 80'(inst_seq_o), 80'(tbl[i].es));
            if (tbl[i].ev) chk($sformatf("t%0d_inst", i), 80'(inst_o), 80'(mk(tbl[i].epc, tbl[i].eex ? 4'd1 : 4'd0)));
            adv();
        end

        drive(1, 2'b11, mk(32'h2000, 4'd0), mk(32'h2004, 4'd0), 0, 0);
        adv();
        for (int k = 0; k < 5; k++) begin
            drive(0, 2'b00, mk(32'h0, 4'd0), mk(32'h0, 4'd0), 0, 0);
            chk("stall_inst", 80'(inst_o), 80'(mk(32'h2000, 4'd0)));
            chk("stall_seq", 80'(inst_seq_o), 80'(6));
            chk("stall_ready", 80'(pkg_ready_o), 80'(0));
            adv();
        end
        drive(0, 2'b00, mk(32'h0, 4'd0), mk(32'h0, 4'd0), 1, 0);
        chk("rel0_last", 80'(inst_last_o), 80'(0));
        adv();
        drive(0, 2'b00, mk(32'h0, 4'd0), mk(32'h0, 4'd0), 1, 0);
        chk("rel1_inst", 80'(inst_o), 80'(mk(32'h2004, 4'd0)));
        chk("rel1_last", 80'(inst_last_o), 80'(1));
        chk("rel1_seq", 80'(inst_seq_o), 80'(7));
        adv();

        do_reset();
        for (int k = 0; k <= 257; k++) begin
            drive(k < 257, 2'b01, mk(32'h3000 + 32'(k) * 4, 4'd0), mk(32'h0, 4'd0), 1, 0);
            if (k > 0) begin
                chk("wrap_valid", 80'(inst_valid_o), 80'(1));
                chk("wrap_seq", 80'(inst_seq_o), 80'((k - 1) % 256));
            end
            adv();
        end
        drive(1, 2'b11, mk(32'h4000, 4'd0), mk(32'h4004, 4'd0), 0, 0);
        adv();
        chk("pre_rst_valid", 80'(inst_valid_o), 80'(1));
        chk("pre_rst_seq", 80'(inst_seq_o), 80'(1));
        do_reset();
        drive(0, 2'b00, mk(32'h0, 4'd0), mk(32'h0, 4'd0), 1, 0);
        chk("post_rst_valid", 80'(inst_valid_o), 80'(0));
        adv();

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else begin
                drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                      mk($urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0),
                      mk($urandom, 4'($urandom_range(0, 15))),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
                adv();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/wired_pkg_dispatch.md
WIRED_PKG_DISPATCH -- requirements
Module: wired_pkg_dispatch

Interface
REQ-001 Parameter: SEQ_WIDTH, default 8, width of the per-instruction sequence tag.
REQ-002 clk  input  1  single clock for the block; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 flush_i  input  1  backend redirect (bpu_correct_t.redirect); discards all held state.
REQ-005 pkg_valid_i  input  1  frontend packet valid.
REQ-006 pkg_ready_o  output  1  block accepts a packet this cycle.
REQ-007 pkg_mask_i  input  2  per-slot valid mask of the incoming packet.
REQ-008 pkg_i  input  2 x pipeline_ctrl_pack_t  incoming two-slot packet.
REQ-009 inst_valid_o  output  1  one instruction is presented downstream.
REQ-010 inst_ready_i  input  1  downstream accepts the presented instruction.
REQ-011 inst_o  output  pipeline_ctrl_pack_t  presented instruction.
REQ-012 inst_seq_o  output  SEQ_WIDTH  sequence tag of the presented instruction.
REQ-013 inst_last_o  output  1  presented instruction is the last one emitted from its packet.

Function
REQ-014 The block SHALL hold at most one packet in registers pkg_q/mask_q, with a slot pointer ptr_q (0/1).
- States: EMPTY (no packet), SLOT0 (slot 0 pending), SLOT1 (slot 1 pending).
REQ-015 pkg_ready_o SHALL be 1 in EMPTY, or when inst_valid_o & inst_ready_i and the current slot is the last pending one.
- Back-to-back packets with no bubble.
REQ-016 On acceptance (pkg_valid_i & pkg_ready_o), the next state SHALL be:
- SLOT0 if mask[0]=1;
- SLOT1 if mask = 2'b10;
- EMPTY if mask = 2'b00 (packet dropped silently, zero outputs).
REQ-017 In SLOT0 or SLOT1, inst_valid_o SHALL be 1, and inst_o SHALL be pkg_q[ptr_q]; combinational from registers only, no input-to-output path.
REQ-018 On an output handshake in SLOT0, the next state SHALL be SLOT1 if mask_q[1]=1 and pkg_q[0].fetch_excp == '0; otherwise the block SHALL return to EMPTY, or load a new packet per REQ-016.
- A slot-0 fetch exception squashes slot 1.
REQ-019 On an output handshake in SLOT1, the block SHALL go to EMPTY or load a new packet per REQ-016.
REQ-020 inst_last_o SHALL be 1 exactly when the handshake in the current state would leave the packet (REQ-018/019).
REQ-021 seq_q SHALL increment by 1 on every output handshake and wrap modulo 2^SEQ_WIDTH; inst_seq_o = seq_q.
REQ-022 Output handshake latency SHALL be 1 cycle from packet acceptance to first inst_valid_o.
- Throughput: one instruction per cycle.
REQ-023 flush_i SHALL force EMPTY next cycle and take priority over a simultaneous packet acceptance or output handshake.
- pkg_ready_o and inst_valid_o behave combinationally as in the current state; any accepted packet is discarded.
- seq_q is NOT reset by flush.
REQ-024 inst_valid_o SHALL not deassert without a handshake, except on flush_i or rst.
- inst_o is stable while inst_valid_o & !inst_ready_i.

Reset
REQ-025 rst SHALL asynchronously set: state EMPTY, ptr_q 0, mask_q 0, seq_q 0.
- Outputs read inst_valid_o=0, inst_last_o=0, pkg_ready_o=1, inst_seq_o=0.
- pkg_q is not reset.
REQ-026 Reset asserted mid-packet SHALL discard the packet immediately, with no output after deassertion until a new packet is accepted.

Structure
REQ-027 pipeline_ctrl_pack_t, fetch_excp_t, and a new dispatch_state_e (EMPTY/SLOT0/SLOT1) SHALL live in the shared wired0 package/defines.
REQ-028 The block SHALL be a single module with no sub-modules; the state register and payload register are local.

Verification
REQ-029 Packet mask 2'b11, inst_ready_i=1 constantly: seq 0,1 emitted on consecutive cycles with inst_last_o=0,1, and pkg_ready_o=1 in the second cycle.
REQ-030 Mask 2'b10 at pc 0x1C004: one instruction = slot 1 with inst_last_o=1; mask 2'b00: accepted, no inst_valid_o, pkg_ready_o stays 1.
REQ-031 Mask 2'b11 with slot-0 fetch_excp nonzero: only slot 0 emitted with inst_last_o=1; slot 1 never appears.
REQ-032 inst_ready_i=0 for 5 cycles in SLOT0: inst_o/inst_seq_o stable, pkg_ready_o=0; release gives the normal sequence.
REQ-033 flush_i coincident with pkg_valid_i and an output handshake in SLOT1: next cycle EMPTY, inst_valid_o=0, seq_q incremented by exactly 1.
REQ-034 SEQ_WIDTH=8, 257 single-slot packets: tags run 0..255,0, with rst mid-stream returning inst_seq_o to 0 asynchronously.
